// File: rtl/t05_wb_sram_master_if.sv
// Classic Wishbone B4 single-cycle bus between the SRAM request master and the SRAM macro.
interface t05_wb_sram_master_if;
   logic        cyc_o;
   logic        stb_o;
   logic        we_o;
   logic [31:0] adr_o;
   logic [31:0] dat_o;
   logic [3:0]  sel_o;
   logic [31:0] dat_i;
   logic        ack_i;

   modport master (
      output cyc_o, stb_o, we_o, adr_o, dat_o, sel_o,
      input  dat_i, ack_i
   );

   modport slave (
      input  cyc_o, stb_o, we_o, adr_o, dat_o, sel_o,
      output dat_i, ack_i
   );
endinterface

// File: rtl/t05_wb_sram_master.sv
// Turns level wr_en/r_en requests into single Wishbone cycles to the SRAM; out-of-window
// addresses are dropped locally and a hung slave is abandoned after TIMEOUT_CYCLES.
module t05_wb_sram_master #(
   parameter logic [31:0] SRAM_BASE      = 32'h3300_0000,
   parameter logic [31:0] SRAM_BYTES     = 32'h0000_4000,
   parameter int          TIMEOUT_CYCLES = 255,
   parameter int          TO_W           = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_en,
   input  logic        r_en,
   input  logic [3:0]  select,
   input  logic [31:0] addr,
   input  logic [31:0] data_i,
   output logic [31:0] data_o,
   output logic        busy_o,
   output logic        err_o,
   output logic [15:0] txn_cnt_o,
   t05_wb_sram_master_if.master wb
);

   localparam logic [31:0]     SRAM_LAST = SRAM_BASE + SRAM_BYTES - 32'd1;
   localparam logic [TO_W-1:0] TO_LIM    = TO_W'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {IDLE, BUS, SKIP} state_t;

   state_t          state;
   logic [TO_W-1:0] to_cnt;
   logic            in_win;

   assign in_win = (addr >= SRAM_BASE) && (addr <= SRAM_LAST);

   // to_cnt holds the 1-based index of the current stb cycle, so the bus is
   // held for exactly TIMEOUT_CYCLES cycles when no ack arrives.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         to_cnt    <= '0;
         data_o    <= '0;
         busy_o    <= 1'b0;
         err_o     <= 1'b0;
         txn_cnt_o <= '0;
         wb.cyc_o  <= 1'b0;
         wb.stb_o  <= 1'b0;
         wb.we_o   <= 1'b0;
         wb.adr_o  <= '0;
         wb.dat_o  <= '0;
         wb.sel_o  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (wr_en || r_en) begin
                  wb.adr_o <= {addr[31:2], 2'b00};
                  wb.dat_o <= data_i;
                  wb.sel_o <= select;
                  wb.we_o  <= wr_en;
                  err_o    <= 1'b0;
                  busy_o   <= 1'b1;
                  if (in_win) begin
                     state    <= BUS;
                     wb.cyc_o <= 1'b1;
                     wb.stb_o <= 1'b1;
                     to_cnt   <= TO_W'(1);
                  end else begin
                     state <= SKIP;
                  end
               end
            end
            BUS: begin
               if (wb.ack_i) begin
                  state     <= IDLE;
                  wb.cyc_o  <= 1'b0;
                  wb.stb_o  <= 1'b0;
                  busy_o    <= 1'b0;
                  to_cnt    <= '0;
                  txn_cnt_o <= txn_cnt_o + 16'd1;
                  if (!wb.we_o) data_o <= wb.dat_i;
               end else if (to_cnt == TO_LIM) begin
                  state    <= IDLE;
                  wb.cyc_o <= 1'b0;
                  wb.stb_o <= 1'b0;
                  busy_o   <= 1'b0;
                  err_o    <= 1'b1;
                  to_cnt   <= '0;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
            end
            SKIP: begin
               state  <= IDLE;
               busy_o <= 1'b0;
            end
            default: begin
               state    <= IDLE;
               busy_o   <= 1'b0;
               wb.cyc_o <= 1'b0;
               wb.stb_o <= 1'b0;
            end
         endcase
      end
   end

endmodule
